hilo_acc_unit: RTL and testbench

Parametrised HI/LO move-and-accumulate unit for the EX stage. It owns a bank of NACC HI/LO accumulator pairs and forwards pending HI/LO writes from the MEM and WB stages. It executes MFHI/MFLO/MTHI/MTLO/MOVZ/MOVN in one cycle and MADD/MADDU/MSUB/MSUBU in two cycles, stalling the pipeline between them. Its outputs feed the EX/MEM latch; the WB-stage HI/LO write commits into the internal bank.

---
 rtl/hilo_acc_unit.sv | 140 ++++++++++++++
 tb/tb_hilo_acc_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_unit.sv
// HI/LO move-and-accumulate unit for the EX stage: NACC HI/LO pairs with MEM/WB forwarding,
// single-cycle moves and two-cycle multiply-accumulate (stall, then accumulate).
module hilo_acc_unit #(
  parameter int DATA_W = 32,
  parameter int NACC   = 1,
  parameter int IDX_W  = (NACC > 1) ? $clog2(NACC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [IDX_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              mem_whilo_i,
  input  logic [IDX_W-1:0]  mem_acc_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic              wb_whilo_i,
  input  logic [IDX_W-1:0]  wb_acc_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [IDX_W-1:0]  wacc_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);
  localparam int PW = 2 * DATA_W;
  localparam logic [IDX_W:0] NACC_L = (IDX_W+1)'(NACC);

  localparam logic [3:0] OP_MFHI  = 4'd1;
  localparam logic [3:0] OP_MFLO  = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd3;
  localparam logic [3:0] OP_MTLO  = 4'd4;
  localparam logic [3:0] OP_MOVZ  = 4'd5;
  localparam logic [3:0] OP_MOVN  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {IDLE, ACC} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          sub_q, sub_d;
  logic [PW-1:0] bank_q [NACC];
  logic [PW-1:0] bank_d [NACC];

  logic          acc_ok, go, signed_op;
  logic [PW-1:0] bank_rd, fwd, mul_a, mul_b, sum;

  always_comb begin
    acc_ok  = ({1'b0, acc_i} < NACC_L);
    go      = valid_i & ~flush_i & acc_ok & ~rst;
    bank_rd = '0;
    for (int i = 0; i < NACC; i++)
      if (acc_i == IDX_W'(i)) bank_rd = bank_q[i];
    // MEM is younger than WB, so its pending write wins
    if (mem_whilo_i && mem_acc_i == acc_i)    fwd = {mem_hi_i, mem_lo_i};
    else if (wb_whilo_i && wb_acc_i == acc_i) fwd = {wb_hi_i, wb_lo_i};
    else                                      fwd = bank_rd;
    signed_op = (op_i == OP_MADD) || (op_i == OP_MSUB);
    mul_a = {{DATA_W{signed_op & reg1_i[DATA_W-1]}}, reg1_i};
    mul_b = {{DATA_W{signed_op & reg2_i[DATA_W-1]}}, reg2_i};
  end

  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < NACC; i++)
      if (wb_whilo_i && wb_acc_i == IDX_W'(i)) bank_d[i] = {wb_hi_i, wb_lo_i};
  end

  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    sub_d      = sub_q;
    sum        = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    wacc_o     = '0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        case (op_i)
          OP_MFHI: begin wreg_o = 1'b1; wdata_o = fwd[PW-1:DATA_W]; end
          OP_MFLO: begin wreg_o = 1'b1; wdata_o = fwd[DATA_W-1:0];  end
          OP_MTHI: begin
            whilo_o = 1'b1; wacc_o = acc_i; hi_o = reg1_i; lo_o = fwd[DATA_W-1:0];
          end
          OP_MTLO: begin
            whilo_o = 1'b1; wacc_o = acc_i; hi_o = fwd[PW-1:DATA_W]; lo_o = reg1_i;
          end
          OP_MOVZ: if (reg2_i == '0) begin wreg_o = 1'b1; wdata_o = reg1_i; end
          OP_MOVN: if (reg2_i != '0) begin wreg_o = 1'b1; wdata_o = reg1_i; end
          OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            // sign/zero-extended operands make the truncated product correct for both flavours
            prod_d     = mul_a * mul_b;
            sub_d      = (op_i == OP_MSUB) || (op_i == OP_MSUBU);
            stallreq_o = 1'b1;
            state_d    = ACC;
          end
          default: ;
        endcase
      end
      ACC: begin
        state_d = IDLE;
        if (go) begin
          sum     = sub_q ? (fwd - prod_q) : (fwd + prod_q);
          whilo_o = 1'b1;
          wacc_o  = acc_i;
          hi_o    = sum[PW-1:DATA_W];
          lo_o    = sum[DATA_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      sub_q   <= 1'b0;
      for (int i = 0; i < NACC; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      sub_q   <= sub_d;
      for (int i = 0; i < NACC; i++) bank_q[i] <= bank_d[i];
    end
  end
endmodule

// File: tb/tb_hilo_acc_unit.sv
// Scoreboard bench: driver pushes expected per-cycle outputs from a reference model,
// a negedge monitor pops and compares for a NACC=4 and a NACC=3 instance.
module tb_hilo_acc_unit;
  typedef struct packed {
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [1:0]  wacc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, valid, mw, ww;
  logic [3:0]  op;
  logic [1:0]  acc, ma, wa;
  logic [31:0] r1, r2, mh, ml, wh, wl;

  logic        wreg4, whilo4, stall4, wreg3, whilo3, stall3;
  logic [31:0] wdata4, hi4, lo4, wdata3, hi3, lo3;
  logic [1:0]  wacc4, wacc3;
  out_t act4, act3;

  hilo_acc_unit #(.DATA_W(32), .NACC(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(valid), .op_i(op), .acc_i(acc),
    .reg1_i(r1), .reg2_i(r2), .mem_whilo_i(mw), .mem_acc_i(ma), .mem_hi_i(mh), .mem_lo_i(ml),
    .wb_whilo_i(ww), .wb_acc_i(wa), .wb_hi_i(wh), .wb_lo_i(wl),
    .wreg_o(wreg4), .wdata_o(wdata4), .whilo_o(whilo4), .wacc_o(wacc4),
    .hi_o(hi4), .lo_o(lo4), .stallreq_o(stall4));

  hilo_acc_unit #(.DATA_W(32), .NACC(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(valid), .op_i(op), .acc_i(acc),
    .reg1_i(r1), .reg2_i(r2), .mem_whilo_i(mw), .mem_acc_i(ma), .mem_hi_i(mh), .mem_lo_i(ml),
    .wb_whilo_i(ww), .wb_acc_i(wa), .wb_hi_i(wh), .wb_lo_i(wl),
    .wreg_o(wreg3), .wdata_o(wdata3), .whilo_o(whilo3), .wacc_o(wacc3),
    .hi_o(hi3), .lo_o(lo3), .stallreq_o(stall3));

  always_comb begin
    act4 = {wreg4, wdata4, whilo4, wacc4, hi4, lo4, stall4};
    act3 = {wreg3, wdata3, whilo3, wacc3, hi3, lo3, stall3};
  end

  int tests = 0, fails = 0;
  out_t q4[$], q3[$];

  // reference model state: per instance, the HI/LO pairs and a pending multiply
  longint unsigned bm [2][4];
  longint unsigned prod [2];
  bit              pend [2];
  bit              sub  [2];
  int              nacc_m [2] = '{4, 3};

  function automatic out_t mk(bit w, logic [31:0] wd, bit hl, logic [1:0] a,
                              logic [31:0] h, logic [31:0] l, bit st);
    out_t o;
    o = {w, wd, hl, a, h, l, st};
    return o;
  endfunction

  task automatic model_step(input int k, output out_t e);
    longint unsigned f, r;
    bit inr, live;
    e   = '0;
    inr = (int'(acc) < nacc_m[k]);
    if (rst) begin
      pend[k] = 0; prod[k] = 0; sub[k] = 0;
      for (int i = 0; i < 4; i++) bm[k][i] = 0;
    end else begin
      if (mw && ma == acc)      f = {mh, ml};
      else if (ww && wa == acc) f = {wh, wl};
      else                      f = inr ? bm[k][acc] : 64'd0;
      live = valid && !flush && inr;
      if (pend[k]) begin
        if (live) begin
          r = sub[k] ? f - prod[k] : f + prod[k];
          e.whilo = 1; e.wacc = acc; e.hi = r[63:32]; e.lo = r[31:0];
        end
        pend[k] = 0;
      end else if (live) begin
        case (op)
          1: begin e.wreg = 1; e.wdata = f[63:32]; end
          2: begin e.wreg = 1; e.wdata = f[31:0]; end
          3: begin e.whilo = 1; e.wacc = acc; e.hi = r1; e.lo = f[31:0]; end
          4: begin e.whilo = 1; e.wacc = acc; e.hi = f[63:32]; e.lo = r1; end
          5: if (r2 == 0) begin e.wreg = 1; e.wdata = r1; end
          6: if (r2 != 0) begin e.wreg = 1; e.wdata = r1; end
          7, 9: begin
            prod[k] = longint'($signed(r1)) * longint'($signed(r2));
            sub[k] = (op == 9); pend[k] = 1; e.stall = 1;
          end
          8, 10: begin
            prod[k] = {32'd0, r1} * {32'd0, r2};
            sub[k] = (op == 10); pend[k] = 1; e.stall = 1;
          end
          default: ;
        endcase
      end
      if (ww && int'(wa) < nacc_m[k]) bm[k][wa] = {wh, wl};
    end
  endtask

  // use_k: push a hand-derived constant for the NACC=4 instance; z3: expect all-zero from NACC=3
  task automatic issue(input bit use_k, input out_t k, input bit z3);
    out_t e4, e3;
    model_step(0, e4);
    model_step(1, e3);
    q4.push_back(use_k ? k : e4);
    if (z3) q3.push_back('0); else q3.push_back(e3);
    @(posedge clk); #1;
  endtask

  task automatic set_def();
    rst = 0; flush = 0; valid = 1; op = 0; acc = 0; r1 = 0; r2 = 0;
    mw = 0; ma = 0; mh = 0; ml = 0; ww = 0; wa = 0; wh = 0; wl = 0;
  endtask

  always @(negedge clk) begin
    out_t e;
    if (q4.size() != 0) begin
      e = q4.pop_front();
      tests++;
      if (act4 !== e) begin
        fails++;
        $display("FAIL nacc4 op=%0d acc=%0d: got %h, want %h", op, acc, act4, e);
      end
    end
    if (q3.size() != 0) begin
      e = q3.pop_front();
      tests++;
      if (act3 !== e) begin
        fails++;
        $display("FAIL nacc3 op=%0d acc=%0d: got %h, want %h", op, acc, act3, e);
      end
    end
  end

  initial begin
    set_def(); rst = 1; valid = 0;
    @(posedge clk); #1;
    issue(1, '0, 0);                                       // reset cycle
    set_def(); valid = 0; op = 1; issue(1, '0, 0);          // not valid
    set_def(); op = 1; issue(1, mk(1, 0, 0, 0, 0, 0, 0), 0);
    set_def(); op = 12; issue(1, '0, 0);                    // reserved opcode
    set_def(); op = 3; r1 = 32'h12345678; mw = 1; ma = 0; mh = 32'hA; ml = 32'hB;
    issue(1, mk(0, 0, 1, 0, 32'h12345678, 32'hB, 0), 0);
    set_def(); op = 3; r1 = 32'h12345678; ww = 1; wa = 0; wh = 32'hD; wl = 32'hC;
    issue(1, mk(0, 0, 1, 0, 32'h12345678, 32'hC, 0), 0);
    set_def(); op = 2; acc = 1; mw = 1; ma = 1; ml = 5; ww = 1; wa = 1; wl = 9;
    issue(1, mk(1, 5, 0, 0, 0, 0, 0), 0);
    set_def(); op = 2; acc = 0; issue(1, mk(1, 32'hC, 0, 0, 0, 0, 0), 0);
    set_def(); op = 2; acc = 1; issue(1, mk(1, 9, 0, 0, 0, 0, 0), 0);
    set_def(); op = 5; r1 = 32'h77; r2 = 0; issue(1, mk(1, 32'h77, 0, 0, 0, 0, 0), 0);
    set_def(); op = 6; r1 = 32'h77; r2 = 0; issue(1, '0, 0);
    // MADD family on pair {0,5} in acc 2
    set_def(); ww = 1; wa = 2; wl = 5; issue(1, '0, 0);
    set_def(); op = 7; acc = 2; r1 = 32'hFFFFFFFF; r2 = 2;
    issue(1, mk(0, 0, 0, 0, 0, 0, 1), 0);
    issue(1, mk(0, 0, 1, 2, 0, 3, 0), 0);
    op = 8;
    issue(1, mk(0, 0, 0, 0, 0, 0, 1), 0);
    issue(1, mk(0, 0, 1, 2, 32'h2, 32'h3, 0), 0);
    // MSUBU wraps; acc 3 is out of range for the NACC=3 instance
    set_def(); op = 10; acc = 3; r1 = 2; r2 = 3;
    issue(1, mk(0, 0, 0, 0, 0, 0, 1), 1);
    issue(1, mk(0, 0, 1, 3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0), 1);
    // flush while accumulating, then flush on issue
    set_def(); op = 7; acc = 2; r1 = 3; r2 = 4;
    issue(1, mk(0, 0, 0, 0, 0, 0, 1), 0);
    flush = 1; issue(1, '0, 0);
    set_def(); op = 2; acc = 2; issue(1, mk(1, 5, 0, 0, 0, 0, 0), 0);
    set_def(); op = 7; acc = 2; r1 = 3; r2 = 4; flush = 1; issue(1, '0, 0);
    set_def(); op = 2; acc = 2; issue(1, mk(1, 5, 0, 0, 0, 0, 0), 0);
    // reset in the middle of an accumulate
    set_def(); op = 9; acc = 2; r1 = 1; r2 = 1;
    issue(1, mk(0, 0, 0, 0, 0, 0, 1), 0);
    rst = 1; issue(1, '0, 0);
    set_def(); op = 2; acc = 2; issue(1, mk(1, 0, 0, 0, 0, 0, 0), 0);
    // MTLO on acc 3, commit through WB, read back
    set_def(); op = 4; acc = 3; r1 = 32'h55AA;
    issue(1, mk(0, 0, 1, 3, 0, 32'h55AA, 0), 1);
    set_def(); ww = 1; wa = 3; wl = 32'h55AA; issue(1, '0, 0);
    set_def(); op = 2; acc = 3; issue(1, mk(1, 32'h55AA, 0, 0, 0, 0, 0), 1);

    for (int n = 0; n < 400; n++) begin
      set_def();
      rst   = ($urandom_range(0, 99) == 0);
      valid = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 9) == 0);
      op    = 4'($urandom_range(0, 15));
      acc   = 2'($urandom_range(0, 3));
      r1    = $urandom();
      r2    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      mw = 1'($urandom_range(0, 1)); ma = 2'($urandom_range(0, 3)); mh = $urandom(); ml = $urandom();
      ww = 1'($urandom_range(0, 1)); wa = 2'($urandom_range(0, 3)); wh = $urandom(); wl = $urandom();
      issue(0, '0, 0);
      if (op >= 7 && op <= 10) begin
        rst   = 0;
        flush = ($urandom_range(0, 7) == 0);
        mw = 1'($urandom_range(0, 1)); ma = 2'($urandom_range(0, 3)); mh = $urandom(); ml = $urandom();
        ww = 1'($urandom_range(0, 1)); wa = 2'($urandom_range(0, 3)); wh = $urandom(); wl = $urandom();
        issue(0, '0, 0);
      end
    end

    set_def();
    @(negedge clk); #1;
    tests++;
    if (q4.size() + q3.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q4.size() + q3.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
